// File: rtl/vlsu_ar_arbiter.sv
// vlsu_ar_arbiter
// ---------------
// Shares the single AXI AR channel of the vector load/store unit between
// NrReq address-generating requesters. It grants round-robin and holds the
// granted AR stable until its handshake completes. Every request uses the
// same AXI ID, so the R bursts come back in AR order. A tag FIFO records the
// grant order, and each R burst is steered to the requester that issued it.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_ar_i           per-requester AR payload
//   req_ar_valid_i     per-requester AR valid
//   req_ar_ready_o     per-requester AR ready (only the winner sees ready)
//   axi_ar_o           arbitrated AR payload towards memory
//   axi_ar_valid_o     arbitrated AR valid
//   axi_ar_ready_i     AR ready from memory
//   axi_r_data_i       R data from memory
//   axi_r_last_i       R last beat from memory
//   axi_r_valid_i      R valid from memory
//   axi_r_ready_o      R ready to memory (ready of the burst owner)
//   req_r_data_o       R data, broadcast to all requesters
//   req_r_last_o       R last, broadcast to all requesters
//   req_r_valid_o      R valid, one-hot to the burst owner
//   req_r_ready_i      per-requester R ready
//   busy_o             a burst is outstanding, an AR is locked or requested

module vlsu_ar_arbiter #(
    parameter int unsigned NrReq          = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned AxiDataWidth   = 64,
    parameter type         axi_ar_t       = logic
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  axi_ar_t                 req_ar_i       [NrReq],
    input  logic [NrReq-1:0]        req_ar_valid_i,
    output logic [NrReq-1:0]        req_ar_ready_o,
    output axi_ar_t                 axi_ar_o,
    output logic                    axi_ar_valid_o,
    input  logic                    axi_ar_ready_i,
    input  logic [AxiDataWidth-1:0] axi_r_data_i,
    input  logic                    axi_r_last_i,
    input  logic                    axi_r_valid_i,
    output logic                    axi_r_ready_o,
    output logic [AxiDataWidth-1:0] req_r_data_o,
    output logic                    req_r_last_o,
    output logic [NrReq-1:0]        req_r_valid_o,
    input  logic [NrReq-1:0]        req_r_ready_i,
    output logic                    busy_o
);

    localparam int unsigned IdxWidth = $clog2(NrReq);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [IdxWidth-1:0] rr_q;
    logic                lock_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic [CntWidth-1:0] cnt_q;
    logic [IdxWidth-1:0] tag_q [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;

    logic [IdxWidth-1:0] sel;
    logic [IdxWidth-1:0] cand;
    logic [IdxWidth-1:0] head;
    logic                found;
    logic                full;
    logic                empty;
    logic                ar_valid;
    logic                push;
    logic                pop;

    // The FIFO depth need not be a power of two, so the pointers wrap explicitly.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        if (32'(p) == MaxOutstanding - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full  = (cnt_q == CntWidth'(MaxOutstanding));
    assign empty = (cnt_q == '0);
    assign head  = tag_q[rd_ptr_q];

    // ---- AR arbitration: round-robin scan, or the locked requester ----
    always_comb begin
        found = 1'b0;
        sel   = rr_q;
        cand  = '0;
        if (lock_q) begin
            // A stalled AR stays with its owner even if a higher-priority
            // requester turns up, so the AR payload cannot change mid-handshake.
            found = req_ar_valid_i[lock_idx_q];
            sel   = lock_idx_q;
        end else begin
            for (int unsigned off = 1; off <= NrReq; off++) begin
                cand = IdxWidth'((32'(rr_q) + off) % NrReq);
                if (!found && req_ar_valid_i[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end
    end

    // A full tag FIFO blocks new ARs. A pop in this cycle frees a slot only
    // in the next cycle, which keeps the push/pop path free of a bypass.
    assign ar_valid = found & ~full;
    assign push     = ar_valid & axi_ar_ready_i;

    always_comb begin
        axi_ar_valid_o = ar_valid;
        axi_ar_o       = '0;
        req_ar_ready_o = '0;
        if (ar_valid) begin
            axi_ar_o            = req_ar_i[sel];
            req_ar_ready_o[sel] = axi_ar_ready_i;
        end
    end

    // ---- R routing: the FIFO head owns the current burst ----
    always_comb begin
        req_r_valid_o = '0;
        axi_r_ready_o = 1'b0;
        if (!empty) begin
            req_r_valid_o[head] = axi_r_valid_i;
            axi_r_ready_o       = req_r_ready_i[head];
        end
    end

    assign req_r_data_o = axi_r_data_i;
    assign req_r_last_o = axi_r_last_i;
    assign pop          = ~empty & axi_r_valid_i & axi_r_ready_o & axi_r_last_i;

    assign busy_o = (cnt_q != '0) | lock_q | (|req_ar_valid_i);

    // ---- Control state ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= IdxWidth'(NrReq - 1);
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (push) begin
                rr_q     <= sel;
                lock_q   <= 1'b0;
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end else if (ar_valid) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ---- Tag storage (data only, no reset needed) ----
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_q[wr_ptr_q] <= sel;
        end
    end

    // Requesters must keep a stalled AR valid and unchanged.
    ar_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (axi_ar_valid_o && !axi_ar_ready_i) |=> (axi_ar_valid_o && $stable(axi_ar_o)));

    // An R beat with no outstanding burst has no owner.
    r_owner_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        axi_r_valid_i |-> !empty);

    cnt_max_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CntWidth'(MaxOutstanding));

    cnt_ovf_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && full));

    cnt_unf_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && !push && empty));

endmodule

// File: doc/vlsu_ar_arbiter.md
Name: vlsu_ar_arbiter

Overview:
- Shares the single AXI AR channel of the vector load/store unit between NrReq address-generating requesters, e.g. the vector address generator and a scatter/gather or prefetch requester.
- Grants fairly with round-robin arbitration and keeps AR stable until the handshake completes.
- Records grant order in a tag FIFO and routes each R burst back to its owner in order, because all requests share one AXI ID.
- Sits between the requesters and the VLSU's AXI master port.

Parameters:
NrReq, 2, number of AR requesters (>=2)
MaxOutstanding, 4, maximum AR bursts in flight awaiting RLAST (tag FIFO depth)
AxiDataWidth, 64, R data width in bits
axi_ar_t, logic, AR channel struct type
IdxWidth, $clog2(NrReq), derived, do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_ar_i  in  NrReq x axi_ar_t  per-requester AR payload
req_ar_valid_i  in  NrReq  per-requester AR valid
req_ar_ready_o  out  NrReq  per-requester AR ready
axi_ar_o  out  axi_ar_t  arbitrated AR payload
axi_ar_valid_o  out  1  arbitrated AR valid
axi_ar_ready_i  in  1  AR ready from memory
axi_r_data_i  in  AxiDataWidth  R data
axi_r_last_i  in  1  R last beat
axi_r_valid_i  in  1  R valid
axi_r_ready_o  out  1  R ready to memory
req_r_data_o  out  AxiDataWidth  R data broadcast to all requesters
req_r_last_o  out  1  R last, broadcast
req_r_valid_o  out  NrReq  R valid, one-hot to burst owner
req_r_ready_i  in  NrReq  per-requester R ready
busy_o  out  1  at least one burst outstanding or AR pending

Behaviour:
- Clock clk_i; reset rst_ni, asynchronous, active-low.
- State: rr_q (IdxWidth), lock_q (1), lock_idx_q (IdxWidth), tag FIFO (MaxOutstanding entries of IdxWidth), cnt_q (0..MaxOutstanding).
- Reset values: rr_q=NrReq-1 (so requester 0 has first priority), lock_q=0, FIFO empty, cnt_q=0.
- During and after reset, with no valid inputs, all outputs are 0.
- AR path is combinational, with zero-cycle latency from req_ar_valid_i to axi_ar_valid_o.
- Arbitration:
  - Applies only when lock_q=0 and cnt_q<MaxOutstanding.
  - Winner is the first valid index scanning rr_q+1, rr_q+2, ... modulo NrReq.
  - axi_ar_o=req_ar_i[winner], axi_ar_valid_o=1, req_ar_ready_o[winner]=axi_ar_ready_i.
  - All other ready outputs are 0.
- Full gating:
  - If cnt_q==MaxOutstanding, then axi_ar_valid_o=0 and all req_ar_ready_o=0.
  - There is no same-cycle bypass: an RLAST pop frees a slot only from the next cycle.
- Lock:
  - If axi_ar_valid_o=1 and axi_ar_ready_i=0, set lock_q=1 and lock_idx_q=winner.
  - While locked, drive the locked requester's payload regardless of the others.
  - Requesters must hold valid and payload stable; an assertion checks this.
  - Clear the lock on handshake.
- On AR handshake: push winner into the FIFO, rr_q<=winner, cnt_q increments.
- R routing:
  - head = FIFO head.
  - If the FIFO is not empty: req_r_valid_o[head]=axi_r_valid_i and axi_r_ready_o=req_r_ready_i[head].
  - If the FIFO is empty: axi_r_ready_o=0 and all req_r_valid_o=0. An R beat arriving in this case is a protocol error, flagged by an assertion.
- Pop on axi_r_valid_i & axi_r_ready_o & axi_r_last_i; cnt_q decrements.
- A simultaneous push and pop in the same cycle leaves cnt_q unchanged, and the FIFO order is preserved.
- Non-last beats never pop.
- busy_o = (cnt_q!=0) | lock_q | (|req_ar_valid_i).
- Reset mid-operation drops all outstanding tags. After a reset, the memory side must not return R beats.
- cnt_q never exceeds MaxOutstanding or goes below 0; both limits are asserted.

Test Plan:
- Req0 and req1 both valid continuously, axi_ar_ready_i=1 → grants alternate 0,1,0,1, starting with 0 after reset.
- Req1 valid and axi_ar_ready_i=0 for 3 cycles, then req0 asserts → axi_ar_o holds req1 payload for all 4 cycles; req0 is granted in the cycle after req1's handshake.
- 4 ARs accepted with no R traffic → 5th request sees axi_ar_valid_o=0 and busy_o=1. RLAST of the first burst, then the next cycle → 5th AR is granted.
- Grants 1,0,1 with R bursts of 2,1,3 beats → req_r_valid_o is one-hot 10,10,01,10,10,10. Holding req_r_ready_i[1]=0 stalls axi_r_ready_o.
- Same cycle as the final RLAST pop at cnt_q=1, a new AR handshakes → cnt_q stays 1 and the new tag is at the FIFO head.
- Reset asserted with 2 bursts outstanding and lock_q=1 → next cycle cnt_q=0, busy_o=0 (no valid inputs), and the first grant goes to requester 0.
